vga_hvsync_gen: RTL and testbench

- Free-running VGA raster timing generator; default timing is 640x480 @ 60 Hz from a ~25.175 MHz pixel clock.
- Produces horizontal and vertical sync, a display-active flag and the current pixel coordinates.
- Sits at the front of every video pipeline; pixel/colour logic decodes hpos/vpos and gates colour with display_on.

---
 rtl/vga_hvsync_gen.sv | 86 ++++++++
 tb/tb_vga_hvsync_gen.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_hvsync_gen.sv
// Free-running VGA raster timing generator (hsync/vsync, display_on, hpos/vpos).
// Define HVSYNC_STROBES_EN to add the registered line_end/frame_end strobes.
module vga_hvsync_gen #(
  parameter int H_DISPLAY   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_DISPLAY   = 480,
  parameter int V_BOTTOM    = 10,
  parameter int V_SYNC      = 2,
  parameter int V_TOP       = 33,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos
`ifdef HVSYNC_STROBES_EN
  ,
  output logic       line_end,
  output logic       frame_end
`endif
);

  localparam logic [9:0] H_LAST       = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST       = 10'(V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1);
  localparam logic [9:0] H_DISP_END   = 10'(H_DISPLAY);
  localparam logic [9:0] V_DISP_END   = 10'(V_DISPLAY);
  localparam logic [9:0] H_SYNC_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] H_SYNC_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_START = 10'(V_DISPLAY + V_BOTTOM);
  localparam logic [9:0] V_SYNC_END   = 10'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

  logic       h_last;
  logic       v_last;
  logic [9:0] hpos_next;
  logic [9:0] vpos_next;
  logic       h_in_sync_next;
  logic       v_in_sync_next;

  always_comb begin
    h_last    = (hpos == H_LAST);
    v_last    = (vpos == V_LAST);
    hpos_next = hpos + 10'd1;
    vpos_next = vpos;
    if (h_last) begin
      hpos_next = '0;
      vpos_next = v_last ? '0 : vpos + 10'd1;
    end
    h_in_sync_next = (hpos_next >= H_SYNC_START) && (hpos_next <= H_SYNC_END);
    v_in_sync_next = (vpos_next >= V_SYNC_START) && (vpos_next <= V_SYNC_END);
  end

  // Syncs are registered from next-state counters so they line up with hpos/vpos.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpos  <= '0;
      vpos  <= '0;
      hsync <= ~SYNC_ACTIVE;
      vsync <= ~SYNC_ACTIVE;
    end else begin
      hpos  <= hpos_next;
      vpos  <= vpos_next;
      hsync <= h_in_sync_next ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync <= v_in_sync_next ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end
  end

  assign display_on = (hpos < H_DISP_END) && (vpos < V_DISP_END);

`ifdef HVSYNC_STROBES_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_end  <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      line_end  <= (hpos_next == H_LAST);
      frame_end <= (hpos_next == H_LAST) && (vpos_next == V_LAST);
    end
  end
`endif

endmodule

// File: tb/tb_vga_hvsync_gen.sv
// Bench for vga_hvsync_gen: a default-timing instance plus a shrunken-timing
// instance (30x17, active-high sync) so whole frames fit in a short run.
module tb_vga_hvsync_gen;

  // Shrunken timing: 16+4+6+4 = 30 pixels/line, 10+2+2+3 = 17 lines, 510 clocks/frame.
  localparam int S_HT = 30;
  localparam int S_VT = 17;

  logic       clk = 1'b0;
  logic       reset;
  logic       check_en;

  logic       d_hsync, d_vsync, d_display_on;
  logic [9:0] d_hpos, d_vpos;
  logic       s_hsync, s_vsync, s_display_on;
  logic [9:0] s_hpos, s_vpos;
`ifdef HVSYNC_STROBES_EN
  logic       d_line_end, d_frame_end, s_line_end, s_frame_end;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_hvsync_gen u_dut_def (
    .clk        (clk),
    .reset      (reset),
    .hsync      (d_hsync),
    .vsync      (d_vsync),
    .display_on (d_display_on),
    .hpos       (d_hpos),
    .vpos       (d_vpos)
`ifdef HVSYNC_STROBES_EN
    ,
    .line_end   (d_line_end),
    .frame_end  (d_frame_end)
`endif
  );

  vga_hvsync_gen #(
    .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
    .V_DISPLAY(10), .V_BOTTOM(2), .V_SYNC(2), .V_TOP(3),
    .SYNC_ACTIVE(1'b1)
  ) u_dut_small (
    .clk        (clk),
    .reset      (reset),
    .hsync      (s_hsync),
    .vsync      (s_vsync),
    .display_on (s_display_on),
    .hpos       (s_hpos),
    .vpos       (s_vpos)
`ifdef HVSYNC_STROBES_EN
    ,
    .line_end   (s_line_end),
    .frame_end  (s_frame_end)
`endif
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
    end
  endfunction

  // Model: clocks elapsed since reset release; raster position is plain div/mod of it.
  int unsigned t;
  always @(posedge clk or posedge reset) begin
    if (reset) t <= 0;
    else       t <= t + 1;
  end

  always @(negedge clk) begin
    int dh, dv, sh, sv;
    if (check_en) begin
      dh = int'(t % 800);
      dv = int'((t / 800) % 525);
      sh = int'(t % S_HT);
      sv = int'((t / S_HT) % S_VT);
      chk("d_hpos", d_hpos, dh);
      chk("d_vpos", d_vpos, dv);
      chk("d_hsync", d_hsync, (dh >= 656 && dh <= 751) ? 0 : 1);
      chk("d_vsync", d_vsync, (dv >= 490 && dv <= 491) ? 0 : 1);
      chk("d_display_on", d_display_on, (dh < 640 && dv < 480) ? 1 : 0);
      chk("s_hpos", s_hpos, sh);
      chk("s_vpos", s_vpos, sv);
      chk("s_hsync", s_hsync, (sh >= 20 && sh <= 25) ? 1 : 0);
      chk("s_vsync", s_vsync, (sv >= 12 && sv <= 13) ? 1 : 0);
      chk("s_display_on", s_display_on, (sh < 16 && sv < 10) ? 1 : 0);
`ifdef HVSYNC_STROBES_EN
      chk("d_line_end", d_line_end, (dh == 799) ? 1 : 0);
      chk("d_frame_end", d_frame_end, (dh == 799 && dv == 524) ? 1 : 0);
      chk("s_line_end", s_line_end, (sh == S_HT - 1) ? 1 : 0);
      chk("s_frame_end", s_frame_end, (sh == S_HT - 1 && sv == S_VT - 1) ? 1 : 0);
`endif
    end
  end

  // Period measurements, independent of the model counter.
  int   cyc = 0;
  int   s_last00, d_last_hf, s_last_vf;
  bit   have_s00, have_dhf, have_svf;
  logic d_hs_prev, s_vs_prev;
  int   n_s00 = 0, n_dhf = 0, n_svf = 0;

  always @(negedge clk) begin
    if (reset) begin
      have_s00  = 1'b0;
      have_dhf  = 1'b0;
      have_svf  = 1'b0;
      d_hs_prev = d_hsync;
      s_vs_prev = s_vsync;
    end else if (check_en) begin
      cyc++;
      if (s_hpos == 10'd0 && s_vpos == 10'd0) begin
        if (have_s00) begin
          chk("frame_period", cyc - s_last00, S_HT * S_VT);
          n_s00++;
        end
        have_s00 = 1'b1;
        s_last00 = cyc;
      end
      if (d_hs_prev == 1'b1 && d_hsync == 1'b0) begin
        if (have_dhf) begin
          chk("hsync_period", cyc - d_last_hf, 800);
          n_dhf++;
        end
        have_dhf  = 1'b1;
        d_last_hf = cyc;
      end
      if (s_vs_prev == 1'b0 && s_vsync == 1'b1) begin
        if (have_svf) begin
          chk("vsync_period", cyc - s_last_vf, S_HT * S_VT);
          n_svf++;
        end
        have_svf  = 1'b1;
        s_last_vf = cyc;
      end
      d_hs_prev = d_hsync;
      s_vs_prev = s_vsync;
    end
  end

  task automatic wait_d(input int hx, input int vy, input int budget, input string name);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (d_hpos == 10'(hx) && d_vpos == 10'(vy)) found = 1'b1;
    end
    chk(name, found, 1);
  endtask

  task automatic wait_s(input int hx, input int vy, input int budget, input string name);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (s_hpos == 10'(hx) && s_vpos == 10'(vy)) found = 1'b1;
    end
    chk(name, found, 1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_d_hpos"}, d_hpos, 0);
    chk({tag, "_d_vpos"}, d_vpos, 0);
    chk({tag, "_d_hsync"}, d_hsync, 1);
    chk({tag, "_d_vsync"}, d_vsync, 1);
    chk({tag, "_d_display_on"}, d_display_on, 1);
    chk({tag, "_s_hpos"}, s_hpos, 0);
    chk({tag, "_s_vpos"}, s_vpos, 0);
    chk({tag, "_s_hsync"}, s_hsync, 0);
    chk({tag, "_s_vsync"}, s_vsync, 0);
    chk({tag, "_s_display_on"}, s_display_on, 1);
`ifdef HVSYNC_STROBES_EN
    chk({tag, "_d_line_end"}, d_line_end, 0);
    chk({tag, "_s_frame_end"}, s_frame_end, 0);
`endif
  endtask

  initial begin
    int n_low, lo_min, lo_max;
    int n_vs, vs_min, vs_max, n_disp, n_disp_bad;
    int n_le, n_fe, fe_h, fe_v;

    reset    = 1'b1;
    check_en = 1'b0;
    #12;
    check_reset_values("rst");

    @(negedge clk);
    #2 reset = 1'b0;
    check_en = 1'b1;
    @(posedge clk);
    #1;
    chk("first_edge_hpos", d_hpos, 1);
    chk("first_edge_vpos", d_vpos, 0);

    // Horizontal boundaries on the default-timing instance.
    wait_d(639, 0, 1000, "reach_639");
    chk("disp_at_639", d_display_on, 1);
    @(negedge clk);
    chk("hpos_640", d_hpos, 640);
    chk("disp_at_640", d_display_on, 0);

    n_low = 0; lo_min = 9999; lo_max = -1; n_le = 0;
    for (int i = 0; i < 800; i++) begin
      if (d_hsync == 1'b0) begin
        n_low++;
        if (int'(d_hpos) < lo_min) lo_min = int'(d_hpos);
        if (int'(d_hpos) > lo_max) lo_max = int'(d_hpos);
      end
`ifdef HVSYNC_STROBES_EN
      if (d_line_end) n_le++;
`endif
      @(negedge clk);
    end
    chk("hsync_low_count", n_low, 96);
    chk("hsync_low_first", lo_min, 656);
    chk("hsync_low_last", lo_max, 751);
`ifdef HVSYNC_STROBES_EN
    chk("d_line_end_per_line", n_le, 1);
`endif

    wait_d(799, 1, 1000, "reach_799_1");
    @(negedge clk);
    chk("hwrap_hpos", d_hpos, 0);
    chk("hwrap_vpos", d_vpos, 2);

    // One whole frame on the shrunken instance, starting at (0,0).
    wait_s(0, 0, 600, "s_reach_origin");
    n_vs = 0; vs_min = 9999; vs_max = -1; n_disp = 0; n_disp_bad = 0;
    n_le = 0; n_fe = 0; fe_h = -1; fe_v = -1;
    for (int i = 0; i < S_HT * S_VT; i++) begin
      if (s_vsync == 1'b1) begin
        n_vs++;
        if (int'(s_vpos) < vs_min) vs_min = int'(s_vpos);
        if (int'(s_vpos) > vs_max) vs_max = int'(s_vpos);
      end
      if (s_display_on) begin
        n_disp++;
        if (s_vpos >= 10'd10) n_disp_bad++;
      end
`ifdef HVSYNC_STROBES_EN
      if (s_line_end) n_le++;
      if (s_frame_end) begin
        n_fe++;
        fe_h = int'(s_hpos);
        fe_v = int'(s_vpos);
      end
`endif
      @(negedge clk);
    end
    chk("vsync_active_clocks", n_vs, 60);
    chk("vsync_first_line", vs_min, 12);
    chk("vsync_last_line", vs_max, 13);
    chk("display_pixels", n_disp, 160);
    chk("display_below_area", n_disp_bad, 0);
    chk("frame_wrap_back_hpos", s_hpos, 0);
    chk("frame_wrap_back_vpos", s_vpos, 0);
`ifdef HVSYNC_STROBES_EN
    chk("s_line_end_per_frame", n_le, S_VT);
    chk("s_frame_end_per_frame", n_fe, 1);
    chk("s_frame_end_hpos", fe_h, S_HT - 1);
    chk("s_frame_end_vpos", fe_v, S_VT - 1);
`endif

    wait_s(S_HT - 1, S_VT - 1, 600, "s_reach_last");
    @(negedge clk);
    chk("vwrap_hpos", s_hpos, 0);
    chk("vwrap_vpos", s_vpos, 0);

    // Asynchronous reset in the middle of a line, between clock edges.
    wait_s(7, 5, 600, "s_reach_7_5");
    #2 reset = 1'b1;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("restart_d_hpos", d_hpos, 1);
    chk("restart_d_vpos", d_vpos, 0);
    chk("restart_s_hpos", s_hpos, 1);
    chk("restart_s_vpos", s_vpos, 0);

    repeat (1700) @(negedge clk);
    chk("frame_periods_seen", (n_s00 != 0) ? 1 : 0, 1);
    chk("hsync_periods_seen", (n_dhf != 0) ? 1 : 0, 1);
    chk("vsync_periods_seen", (n_svf != 0) ? 1 : 0, 1);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
